// File: rtl/cpu_pkg.sv
// Shared types for the fetch path: FSM state encoding and next-PC select codes.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_J   = 2'b10;
  localparam logic [1:0] PCS_JR  = 2'b11;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC mux: sequential, branch, J-type and jump-register targets.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [1:0]        pc_src,
  input  logic              branch_taken,
  input  logic [15:0]       imm16,
  input  logic [25:0]       jtarget,
  input  logic [ADDR_W-1:0] jr_addr,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] p4;
  logic [31:0]       off32;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] jump_tgt;

  assign p4     = pc + ADDR_W'(4);
  // word offset, sign-extended and scaled to bytes; truncation keeps sums modulo 2^ADDR_W
  assign off32  = {{14{imm16[15]}}, imm16, 2'b00};
  assign br_off = off32[ADDR_W-1:0];

  if (ADDR_W > 28) begin : g_jwide
    assign jump_tgt = {p4[ADDR_W-1:28], jtarget, 2'b00};
  end else begin : g_jnarrow
    logic [27:0] jt_full;
    assign jt_full  = {jtarget, 2'b00};
    assign jump_tgt = jt_full[ADDR_W-1:0];
  end

  always_comb begin
    next_pc = p4;
    case (pc_src)
      PCS_SEQ: next_pc = p4;
      PCS_BR:  next_pc = branch_taken ? (p4 + br_off) : p4;
      PCS_J:   next_pc = jump_tgt;
      PCS_JR:  next_pc = jr_addr;
      default: next_pc = p4;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, fetch FSM and imem handshake. Define PC_TRAP_EN to redirect
// misaligned targets to TRAP_VEC with a trap pulse; otherwise targets are word-aligned.
//
// state | meaning
// FETCH | present pc; request is raised on leaving
// WAIT  | imem_req held, waiting for imem_ack
// EXEC  | instr valid; advance when pc_wre=1
// HALT  | idle until reset
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0
`ifdef PC_TRAP_EN
  , parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(32'h0000_0080)
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  input  logic              pc_wre,
  input  logic [1:0]        pc_src,
  input  logic              branch_taken,
  input  logic [15:0]       imm16,
  input  logic [25:0]       jtarget,
  input  logic [ADDR_W-1:0] jr_addr,
  input  logic              halt,
  output logic              trap
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] pc_load;
  logic              misaligned;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc           (pc),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .jtarget      (jtarget),
    .jr_addr      (jr_addr),
    .next_pc      (next_pc)
  );

`ifdef PC_TRAP_EN
  assign misaligned = (next_pc[1:0] != 2'b00);
  assign pc_load    = misaligned ? TRAP_VEC : next_pc;
`else
  assign misaligned = 1'b0;
  assign pc_load    = next_pc & ~ADDR_W'(3);
`endif

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_VEC;
      imem_req    <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      trap        <= 1'b0;
    end else begin
      trap <= 1'b0;
      case (state)
        FETCH: begin
          imem_req <= 1'b1;
          state    <= WAIT;
        end
        WAIT: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (pc_wre) begin
            instr_valid <= 1'b0;
            if (halt) begin
              state <= HALT;
            end else begin
              pc    <= pc_load;
              trap  <= misaligned;
              state <= FETCH;
            end
          end
        end
        HALT: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomised self-checking bench for pc_fetch_unit with a behavioural reference model.
module tb_pc_fetch_unit;

  localparam int ADDR_W = 32;
  localparam int PH_FETCH = 0, PH_WAIT = 1, PH_EXEC = 2, PH_HALT = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack = 1'b0;
  logic [31:0]       imem_rdata = '0;
  logic [31:0]       instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              pc_wre = 1'b0;
  logic [1:0]        pc_src = 2'b00;
  logic              branch_taken = 1'b0;
  logic [15:0]       imm16 = '0;
  logic [25:0]       jtarget = '0;
  logic [ADDR_W-1:0] jr_addr = '0;
  logic              halt = 1'b0;
  logic              trap;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_wre       (pc_wre),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .imm16        (imm16),
    .jtarget      (jtarget),
    .jr_addr      (jr_addr),
    .halt         (halt),
    .trap         (trap)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Target address from the selection rules, all arithmetic modulo 2^32.
  function automatic logic [31:0] ref_target(input logic [31:0] cur, input logic [1:0] src,
                                             input logic bt, input logic [15:0] imm,
                                             input logic [25:0] jt, input logic [31:0] jr);
    logic [31:0] p4;
    int          off;
    p4  = cur + 32'd4;
    off = int'($signed(imm)) * 4;
    case (src)
      2'd0:    return p4;
      2'd1:    return bt ? p4 + 32'(off) : p4;
      2'd2:    return (p4 & 32'hF000_0000) + (32'(jt) * 32'd4);
      default: return jr;
    endcase
  endfunction

  // {trap, new pc} for a resolved target
  function automatic logic [32:0] ref_load(input logic [31:0] tgt);
`ifdef PC_TRAP_EN
    if (tgt % 4 != 0) return {1'b1, 32'h0000_0080};
    else return {1'b0, tgt};
`else
    return {1'b0, tgt - (tgt % 4)};
`endif
  endfunction

  int          m_phase;
  logic [31:0] m_pc, m_instr;
  logic        m_req, m_valid, m_trap;
  logic [32:0] m_ld;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= PH_FETCH;
      m_pc    <= 32'd0;
      m_instr <= 32'd0;
      m_req   <= 1'b0;
      m_valid <= 1'b0;
      m_trap  <= 1'b0;
    end else begin
      m_trap <= 1'b0;
      if (m_phase == PH_FETCH) begin
        m_phase <= PH_WAIT;
        m_req   <= 1'b1;
      end else if (m_phase == PH_WAIT && imem_ack) begin
        m_instr <= imem_rdata;
        m_req   <= 1'b0;
        m_valid <= 1'b1;
        m_phase <= PH_EXEC;
      end else if (m_phase == PH_EXEC && pc_wre) begin
        m_valid <= 1'b0;
        if (halt) m_phase <= PH_HALT;
        else begin
          m_ld     = ref_load(ref_target(m_pc, pc_src, branch_taken, imm16, jtarget, jr_addr));
          m_pc    <= m_ld[31:0];
          m_trap  <= m_ld[32];
          m_phase <= PH_FETCH;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("imem_req", {31'd0, imem_req}, {31'd0, m_req});
      check("imem_addr", imem_addr, m_pc);
      check("pc", pc, m_pc);
      check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
      check("instr", instr, m_instr);
      check("trap", {31'd0, trap}, {31'd0, m_trap});
    end
  end

  // Runs one instruction from FETCH; addr returns the address presented during WAIT.
  task automatic do_instr(input int delay, input int stalls, input logic fack,
                          input logic [1:0] src, input logic bt, input logic [15:0] imm,
                          input logic [25:0] jt, input logic [31:0] jr, input logic hlt,
                          output logic [31:0] addr);
    logic [31:0] data;
    int n;
    addr = 32'hDEAD_BEEF;
    if (fack) imem_ack = 1'b1;
    n = 0;
    while (!imem_req && n < 20) begin
      @(posedge clk); #1;
      imem_ack = 1'b0;
      n++;
    end
    if (!imem_req) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: imem_req stayed %b, required 1", imem_req);
      return;
    end
    addr = imem_addr;
    repeat (delay) begin @(posedge clk); #1; end
    data       = $urandom;
    imem_rdata = data;
    imem_ack   = 1'b1;
    @(posedge clk); #1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    check("instr_latch", instr, data);
    repeat (stalls) begin
      halt   = 1'($urandom_range(0, 1));
      pc_src = 2'($urandom);
      @(posedge clk); #1;
    end
    pc_src = src; branch_taken = bt; imm16 = imm; jtarget = jt; jr_addr = jr;
    halt = hlt; pc_wre = 1'b1;
    @(posedge clk); #1;
    pc_wre = 1'b0;
    halt   = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_trap", {31'd0, trap}, 32'd0);
    rst_n = 1'b1;

    do_instr(0, 0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, a);
    check("seq_addr0", a, 32'h0);
    do_instr(0, 0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, a);
    check("seq_addr4", a, 32'h4);
    do_instr(0, 0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h10, 1'b0, a);
    check("seq_addr8", a, 32'h8);
    do_instr(0, 0, 1'b0, 2'd1, 1'b1, 16'hFFFE, 26'h0, 32'h0, 1'b0, a);
    check("jr_addr10", a, 32'h10);
    do_instr(0, 0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h10, 1'b0, a);
    check("br_taken", a, 32'h0C);
    do_instr(0, 0, 1'b0, 2'd1, 1'b0, 16'hFFFE, 26'h0, 32'h0, 1'b0, a);
    do_instr(0, 0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h4000_0000, 1'b0, a);
    check("br_not_taken", a, 32'h14);
    do_instr(0, 0, 1'b0, 2'd2, 1'b0, 16'h0, 26'h0000100, 32'h0, 1'b0, a);
    do_instr(0, 0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h200, 1'b0, a);
    check("jump_addr", a, 32'h4000_0400);
    do_instr(5, 3, 1'b1, 2'd3, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0, a);
    check("jr_addr200", a, 32'h200);
    do_instr(1, 0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, a);
    check("wrap_from", a, 32'hFFFF_FFFC);
    do_instr(0, 0, 1'b1, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0004_0000, 1'b0, a);
    check("wrap_to_zero", a, 32'h0);
    do_instr(0, 0, 1'b0, 2'd1, 1'b1, 16'h8000, 26'h0, 32'h0, 1'b0, a);
    do_instr(0, 0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h202, 1'b0, a);
    check("imm_min_offset", a, 32'h0002_0004);
`ifdef PC_TRAP_EN
    check("trap_pulse", {31'd0, trap}, 32'd1);
`else
    check("trap_tied", {31'd0, trap}, 32'd0);
`endif
    do_instr(0, 0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, a);
`ifdef PC_TRAP_EN
    check("trap_vec", a, 32'h80);
`else
    check("misalign_forced", a, 32'h200);
`endif

    for (int i = 0; i < 40; i++) begin
      do_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), 1'($urandom),
               2'($urandom), 1'($urandom), 16'($urandom), 26'($urandom), $urandom,
               1'b0, a);
    end

    do_instr(0, 1, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, a);
    for (int i = 0; i < 20; i++) begin
      imem_ack = 1'($urandom);
      @(posedge clk); #1;
      check("halt_req", {31'd0, imem_req}, 32'd0);
    end
    imem_ack = 1'b0;
    check("halt_valid", {31'd0, instr_valid}, 32'd0);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    do_instr(0, 0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, 32'h300, 1'b0, a);
    check("post_halt_addr", a, 32'h0);
    @(posedge clk); #1;
    check("wait_req", {31'd0, imem_req}, 32'd1);
    check("wait_addr", imem_addr, 32'h300);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'd0, imem_req}, 32'd0);
    check("async_rst_pc", pc, 32'h0);
    rst_n = 1'b1;
    do_instr(0, 0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, a);
    check("refetch_addr", a, 32'h0);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
